pkt_stream_tx: RTL
==================

PKT_STREAM_TX -- requirements
Module: pkt_stream_tx

Interface
REQ-001 Parameter DEPTH, default 2048: data buffer size in bytes, power of 2, at least 64.
REQ-002 Parameter FRAMES, default 8: maximum number of committed frames queued, power of 2.
REQ-003 Parameter IFG, default 10: idle cycles between transmitted frames, at least 2.
REQ-004 clk  in  1: single clock, all logic on its rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 din  in  8: ingress byte, sampled when vin=1.
REQ-007 vin  in  1: ingress valid; a frame is one contiguous run of vin=1 cycles.
REQ-008 dout  out  8: egress byte, valid when vout=1.
REQ-009 vout  out  1: egress valid; each frame is one contiguous run, with no gaps inside a frame.
REQ-010 queued  out  $clog2(FRAMES)+1: number of committed frames not yet fully sent.
REQ-011 drop_cnt  out  16: count of dropped ingress frames; saturates at 0xFFFF.

Function
REQ-012 A frame ends on the first cycle vin=0 after vin=1 (the end cycle); commit happens on that cycle's edge, recording the byte count in the length FIFO.
REQ-013 Write side stores bytes at a tentative pointer; the committed pointer advances only at commit.
REQ-014 Drop rule: if a byte arrives with the data buffer full (occupancy DEPTH), or the frame ends with the length FIFO full, the frame is dropped:
- tentative pointer rewinds to committed pointer
- drop_cnt increments once
- remaining bytes of that frame are ignored
REQ-015 Byte count of a frame is at most DEPTH; counters are $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
REQ-016 Transmit FSM has four states:
- IDLE: go to LOAD when queued != 0
- LOAD: pop length, issue first RAM read (read latency 1), go to SEND
- SEND: vout=1 per byte; after the last byte go to GAP
- GAP: vout=0 for IFG-1 cycles, then go to LOAD if queued != 0, else IDLE
REQ-017 Latency: with the FSM idle, the first byte of a frame appears on dout exactly 2 cycles after its end cycle.
REQ-018 Back-to-back queued frames have exactly IFG cycles of vout=0 between them.
REQ-019 Buffer space for a frame is released byte by byte as it is read; the freed-space count is visible to the write side the next cycle.
REQ-020 Simultaneous commit and pop in the same cycle leave queued unchanged.
REQ-021 A frame arriving while another frame is transmitting is accepted concurrently; write and read proceed independently.
REQ-022 dout holds its last value when vout=0; its value there is don't-care for checkers.

Reset
REQ-023 While rst=1:
- vout=0, dout=0, queued=0, drop_cnt=0
- all pointers and the length FIFO cleared
- FSM in IDLE
REQ-024 Reset mid-transmit truncates the egress frame immediately; reset mid-ingress discards the partial frame.
REQ-025 After rst deasserts, a frame whose vin run started while rst=1 is ignored until vin has been low for one cycle.

Structure
REQ-026 Package pkt_tx_pkg holds the FSM state enum (IDLE, LOAD, SEND, GAP) and the default values of DEPTH, FRAMES and IFG.
REQ-027 Sub-module pkt_tx_ram is a simple dual-port RAM, 8-bit wide, DEPTH entries, with registered read; the length FIFO is inline in pkt_stream_tx.

Verification
REQ-028 Single frame, bytes 0x01..0x40 (64 bytes), on an idle block -> vout high 64 cycles starting 2 cycles after the end cycle, data identical, queued returns to 0.
REQ-029 Three 60-byte frames sent back-to-back with 1 idle ingress cycle between them -> three egress frames in order, each separated by exactly IFG=10 low cycles.
REQ-030 DEPTH=64, 100-byte frame -> frame dropped, drop_cnt=1, no egress; a following 10-byte frame is transmitted intact.
REQ-031 FRAMES=8, nine 4-byte frames sent while egress is stalled behind a long first frame -> ninth frame dropped only if the length FIFO is full at its end cycle; drop_cnt matches the model.
REQ-032 rst pulsed for 1 cycle at byte 20 of egress -> vout=0 at once, queued=0, and a subsequent frame transmits correctly.
REQ-033 Random frames of 1..300 bytes at random gaps for 10k cycles against a scoreboard -> every non-dropped frame is bit-exact, in order, and IFG is never violated.

Source files
------------

// File: rtl/pkt_tx_pkg.sv
// Shared types and default sizing for the packet stream transmitter.
package pkt_tx_pkg;

    localparam int DEF_DEPTH  = 2048;
    localparam int DEF_FRAMES = 8;
    localparam int DEF_IFG    = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } tx_state_e;

endpackage

// File: rtl/pkt_tx_ram.sv
// Simple dual-port byte RAM, one write and one read port, read data registered (latency 1).
// The read register only updates on a read, so the last value is held between reads.
module pkt_tx_ram #(
    parameter int DEPTH = 2048
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [7:0]               rdata_o
);
    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_stream_tx.sv
// Store-and-forward byte stream transmitter: frames are committed to a ring buffer and replayed with a fixed IFG.
// First egress byte 2 cycles after the ingress end cycle when idle; no backpressure, overflow drops whole frames.
module pkt_stream_tx
    import pkt_tx_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int FRAMES = DEF_FRAMES,
    parameter int IFG    = DEF_IFG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              din,
    input  logic                    vin,
    output logic [7:0]              dout,
    output logic                    vout,
    output logic [$clog2(FRAMES):0] queued,
    output logic [15:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAMES);
    localparam int GW = $clog2(IFG);
    localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [FW:0]   LF_FULL  = (FW+1)'(FRAMES);
    localparam logic [FW:0]   LF_ONE   = (FW+1)'(1);

    logic [CW-1:0] wr_ptr_q, cm_ptr_q, rd_ptr_q, tlen_q, remain_q, occ;
    logic          active_q, ign_q;
    logic [15:0]   drop_q;
    logic [CW-1:0] lf_mem [FRAMES];
    logic [FW-1:0] lf_wp_q, lf_rp_q;
    logic [FW:0]   lf_cnt_q, lf_cnt_d;
    logic [FW:0]   queued_q, queued_d;
    tx_state_e     state_q;
    logic [GW-1:0] gap_q;
    logic          vout_q;
    logic          wr_en, commit, drop, pop, done, rd_en, has_frame;
    logic [7:0]    rd_data;

    // Occupancy includes uncommitted bytes; the read pointer is registered, so freed space shows up a cycle later.
    assign occ = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_en  = 1'b0;
        commit = 1'b0;
        drop   = 1'b0;
        if (vin) begin
            if (!ign_q) begin
                if (occ == FULL_OCC) begin
                    drop = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end
        end else if (active_q) begin
            if (lf_cnt_q == LF_FULL) begin
                drop = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            tlen_q   <= '0;
            active_q <= 1'b0;
            ign_q    <= 1'b1;
            drop_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ONE;
                tlen_q   <= tlen_q + ONE;
                active_q <= 1'b1;
            end
            if (drop) begin
                wr_ptr_q <= cm_ptr_q;
                tlen_q   <= '0;
                active_q <= 1'b0;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
            if (commit) begin
                cm_ptr_q <= wr_ptr_q;
                tlen_q   <= '0;
                active_q <= 1'b0;
            end
            // A run that was dropped, or that began during reset, is skipped until vin drops.
            ign_q <= vin ? (ign_q | drop) : 1'b0;
        end
    end

    assign pop       = (state_q == LOAD);
    assign done      = (state_q == SEND) && (remain_q == ONE);
    assign rd_en     = (state_q == LOAD) || ((state_q == SEND) && (remain_q != ONE));
    assign has_frame = (lf_cnt_q != '0) || commit;

    always_comb begin
        lf_cnt_d = lf_cnt_q;
        if (commit && !pop) begin
            lf_cnt_d = lf_cnt_q + LF_ONE;
        end else if (pop && !commit) begin
            lf_cnt_d = lf_cnt_q - LF_ONE;
        end
        queued_d = queued_q;
        if (commit && !done) begin
            queued_d = queued_q + LF_ONE;
        end else if (done && !commit) begin
            queued_d = queued_q - LF_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            lf_mem[lf_wp_q] <= tlen_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lf_wp_q  <= '0;
            lf_rp_q  <= '0;
            lf_cnt_q <= '0;
            queued_q <= '0;
        end else begin
            if (commit) begin
                lf_wp_q <= lf_wp_q + 1'b1;
            end
            if (pop) begin
                lf_rp_q <= lf_rp_q + 1'b1;
            end
            lf_cnt_q <= lf_cnt_d;
            queued_q <= queued_d;
        end
    end

    // IDLE and GAP also see a same-cycle commit so an idle block starts the frame with 2-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vout_q   <= 1'b0;
            remain_q <= '0;
            gap_q    <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + ONE;
            end
            case (state_q)
                IDLE: begin
                    if (has_frame) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    remain_q <= lf_mem[lf_rp_q];
                    vout_q   <= 1'b1;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (remain_q == ONE) begin
                        vout_q  <= 1'b0;
                        gap_q   <= GW'(IFG - 2);
                        state_q <= GAP;
                    end else begin
                        remain_q <= remain_q - ONE;
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= has_frame ? LOAD : IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pkt_tx_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    assign dout     = rd_data;
    assign vout     = vout_q;
    assign queued   = queued_q;
    assign drop_cnt = drop_q;

endmodule
